// File: rtl/data_mem_bytelane.sv
// ---------------------------------------------------------------------------
// data_mem_bytelane
//   Byte-addressed, word-organised data memory for the single-cycle MIPS
//   datapath. Supports byte/half/word loads and stores, sign or zero
//   extension on loads, sticky misalignment / out-of-range flags, a debug
//   read port and a one-word-per-cycle clear sweep after reset.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   addr         byte address from the ALU
//   wd           store data (low bits used for byte/half stores)
//   we / re      store enable / load enable (re only feeds error detection)
//   size         00 byte, 01 half, 10 word, 11 illegal
//   uns          1 = zero-extend loads, 0 = sign-extend
//   rd           combinational load data (0 when access is not ok)
//   busy         high while the clear sweep runs
//   misalign_err sticky misalignment / illegal-size flag
//   oob_err      sticky out-of-range flag
//   err_clr      synchronous clear of both sticky flags (a set wins)
//   dbg_addr     word index for the debug port
//   dbg_data     combinational word at dbg_addr, 0 while busy
// ---------------------------------------------------------------------------
module data_mem_bytelane #(
    parameter int DEPTH        = 256,
    parameter bit CLEAR_ON_RST = 1'b1,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   addr,
    input  logic [31:0]   wd,
    input  logic          we,
    input  logic          re,
    input  logic [1:0]    size,
    input  logic          uns,
    output logic [31:0]   rd,
    output logic          busy,
    output logic          misalign_err,
    output logic          oob_err,
    input  logic          err_clr,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            mis_q, mis_d;
    logic            oob_q, oob_d;
    logic [31:0]     mem_q [DEPTH];

    logic [AW-1:0]   widx_s;
    logic [1:0]      lane_s;
    logic            in_range_s;
    logic            aligned_s;
    logic            busy_s;
    logic            ok_s;
    logic [3:0]      be_s;
    logic [31:0]     wdat_s;
    logic            set_mis_s;
    logic            set_oob_s;

    // Select the addressed byte/half of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  sz,
        input logic        unsgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (sz)
            2'b00:   r = unsgn ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = unsgn ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Address decode and access qualification.
    always_comb begin
        widx_s     = addr[AW+1:2];
        lane_s     = addr[1:0];
        in_range_s = (addr[31:AW+2] == {(30-AW){1'b0}});
        case (size)
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = (addr[0] == 1'b0);
            2'b10:   aligned_s = (addr[1:0] == 2'b00);
            default: aligned_s = 1'b0;
        endcase
        busy_s = (state_q == ST_CLEAR);
        ok_s   = aligned_s && in_range_s && !busy_s;
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be_s   = 4'b0000;
        wdat_s = wd;
        case (size)
            2'b00: begin
                wdat_s = {4{wd[7:0]}};
                case (lane_s)
                    2'd0:    be_s = 4'b0001;
                    2'd1:    be_s = 4'b0010;
                    2'd2:    be_s = 4'b0100;
                    2'd3:    be_s = 4'b1000;
                    default: be_s = 4'b0000;
                endcase
            end
            2'b01: begin
                wdat_s = {2{wd[15:0]}};
                be_s   = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                be_s = 4'b1111;
            end
            default: begin
                be_s = 4'b0000;
            end
        endcase
        // A store that is not ok is dropped entirely.
        if (!(we && ok_s)) begin
            be_s = 4'b0000;
        end else begin
            be_s = be_s;
        end
    end

    // Next-state logic for the clear sweep.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flags: only IDLE accesses set them, and a set beats err_clr.
    always_comb begin
        set_mis_s = (state_q == ST_IDLE) && (we || re) && !aligned_s;
        set_oob_s = (state_q == ST_IDLE) && (we || re) && !in_range_s;
        if (set_mis_s) begin
            mis_d = 1'b1;
        end else if (err_clr) begin
            mis_d = 1'b0;
        end else begin
            mis_d = mis_q;
        end
        if (set_oob_s) begin
            oob_d = 1'b1;
        end else if (err_clr) begin
            oob_d = 1'b0;
        end else begin
            oob_d = oob_q;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
            clr_idx_q <= {AW{1'b0}};
            mis_q     <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            mis_q     <= mis_d;
            oob_q     <= oob_d;
        end
    end

    // Storage array: the sweep has priority, otherwise lane-masked stores.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= wdat_s[8*i +: 8];
                end
            end
        end
    end

    // Combinational load path (old data is returned on a same-cycle store).
    always_comb begin
        if (ok_s) begin
            rd = load_extend(mem_q[widx_s], lane_s, size, uns);
        end else begin
            rd = 32'h0000_0000;
        end
    end

    // Debug port and status outputs.
    always_comb begin
        if (busy_s) begin
            dbg_data = 32'h0000_0000;
        end else begin
            dbg_data = mem_q[dbg_addr];
        end
        busy         = busy_s;
        misalign_err = mis_q;
        oob_err      = oob_q;
    end

endmodule

// File: tb/tb_data_mem_bytelane.sv
module tb_data_mem_bytelane;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wd;
    logic        we, re, uns, err_clr;
    logic [1:0]  size;
    logic [AW-1:0] dbg_addr;
    logic [31:0] rd, dbg_data;
    logic        busy, misalign_err, oob_err;

    logic [31:0] nc_rd, nc_dbg;
    logic        nc_busy, nc_mis, nc_oob;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] expv;

    always #5 clk = ~clk;

    data_mem_bytelane #(.DEPTH(DEPTH), .CLEAR_ON_RST(1'b1)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wd(wd), .we(we), .re(re),
        .size(size), .uns(uns), .rd(rd), .busy(busy),
        .misalign_err(misalign_err), .oob_err(oob_err), .err_clr(err_clr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    data_mem_bytelane #(.DEPTH(4), .CLEAR_ON_RST(1'b0)) u_nc (
        .clk(clk), .rst(rst), .addr(32'h0000_0000), .wd(32'h0000_0000),
        .we(1'b0), .re(1'b0), .size(2'b10), .uns(1'b0), .rd(nc_rd),
        .busy(nc_busy), .misalign_err(nc_mis), .oob_err(nc_oob),
        .err_clr(1'b0), .dbg_addr(2'b00), .dbg_data(nc_dbg)
    );

    task automatic idle();
        addr = 32'h0; wd = 32'h0; we = 1'b0; re = 1'b0;
        size = 2'b10; uns = 1'b0; err_clr = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic r,
                          input logic [1:0] s, input logic u);
        addr = a; wd = d; we = w; re = r; size = s; uns = u; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic nc_seen;
        rst = 1'b0; idle(); dbg_addr = 8'd0;
        re = 1'b1; addr = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        exp_q.push_back(32'h1);
        checks++; expv = exp_q.pop_front();
        if ({31'h0, busy} !== expv) begin errors++; $display("FAIL reset_busy: got %0h want %0h", busy, expv); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL reset_rd: got %h want %h", rd, expv); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if (dbg_data !== expv) begin errors++; $display("FAIL reset_dbg: got %h want %h", dbg_data, expv); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL reset_flags: got %b%b want 00", misalign_err, oob_err); end
        idle();
        @(negedge clk); rst = 1'b1;
        // First sweep: count busy edges; the no-clear build must be idle at edge 1.
        n = 0; nc_seen = 1'b1;
        exp_q.push_back(32'd256);
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
            if (n == 1) nc_seen = nc_busy;
        end
        checks++; expv = exp_q.pop_front();
        if (n !== int'(expv)) begin errors++; $display("FAIL sweep_len: got %0d want %0d", n, expv); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if ({31'h0, nc_seen} !== expv) begin errors++; $display("FAIL noclear_busy: got %b want 0", nc_seen); end
        // Restart: reset pulse at edge 100 of a new sweep.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        n = 0;
        while (n < 100) begin @(posedge clk); n++; end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        // Stores and bad accesses during the sweep must be dropped silently.
        access(32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0);
        n = 0;
        exp_q.push_back(32'd256);
        while (busy === 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
            if (n == 128) access(32'h403, 32'hDEADBEEF, 1'b1, 1'b1, 2'b10, 1'b0);
            if (n == 250) idle();
        end
        checks++; expv = exp_q.pop_front();
        if (n !== int'(expv)) begin errors++; $display("FAIL restart_len: got %0d want %0d", n, expv); end
        @(negedge clk); idle();
        #1;
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL busy_noflags: got %b%b want 00", misalign_err, oob_err); end
        access(32'h0, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0); #1;
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL busy_drop_lw0: got %h want %h", rd, expv); end
        for (int k = 0; k < 3; k++) begin
            dbg_addr = (k == 0) ? 8'd0 : ((k == 1) ? 8'd128 : 8'd255);
            #1;
            exp_q.push_back(32'h0);
            checks++; expv = exp_q.pop_front();
            if (dbg_data !== expv) begin errors++; $display("FAIL sweep_dbg[%0d]: got %h want %h", dbg_addr, dbg_data, expv); end
        end
        idle();
    endtask

    task automatic test_word_byte();
        @(negedge clk); access(32'h10, 32'h11223344, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk); access(32'h12, 32'h000000AA, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk); access(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        exp_q.push_back(32'h11AA3344);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lw_0x10: got %h want %h", rd, expv); end
        access(32'h12, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
        exp_q.push_back(32'hFFFFFFAA);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lb_0x12: got %h want %h", rd, expv); end
        uns = 1'b1;
        exp_q.push_back(32'h000000AA);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lbu_0x12: got %h want %h", rd, expv); end
        access(32'h11, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1);
        exp_q.push_back(32'h00000033);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lbu_0x11: got %h want %h", rd, expv); end
        dbg_addr = 8'd4;
        exp_q.push_back(32'h11AA3344);
        #1; checks++; expv = exp_q.pop_front();
        if (dbg_data !== expv) begin errors++; $display("FAIL dbg_w4: got %h want %h", dbg_data, expv); end
        idle();
    endtask

    task automatic test_half();
        @(negedge clk); access(32'h22, 32'h5A5A8001, 1'b1, 1'b0, 2'b01, 1'b0);
        @(negedge clk); access(32'h22, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
        exp_q.push_back(32'hFFFF8001);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lh_0x22: got %h want %h", rd, expv); end
        uns = 1'b1;
        exp_q.push_back(32'h00008001);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lhu_0x22: got %h want %h", rd, expv); end
        access(32'h20, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0);
        exp_q.push_back(32'h00000000);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL lh_0x20: got %h want %h", rd, expv); end
        idle();
    endtask

    task automatic test_misalign();
        @(negedge clk); access(32'h13, 32'hCAFEF00D, 1'b1, 1'b0, 2'b10, 1'b0);
        exp_q.push_back(32'h0);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL sw_0x13_rd: got %h want %h", rd, expv); end
        @(negedge clk); access(32'h21, 32'h0000BEEF, 1'b0, 1'b1, 2'b01, 1'b0);
        @(negedge clk); idle(); dbg_addr = 8'd4;
        #1;
        exp_q.push_back(32'h2);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL misalign_set: got %b%b want 10", misalign_err, oob_err); end
        exp_q.push_back(32'h11AA3344);
        checks++; expv = exp_q.pop_front();
        if (dbg_data !== expv) begin errors++; $display("FAIL misalign_nowrite: got %h want %h", dbg_data, expv); end
        err_clr = 1'b1;
        @(negedge clk); idle(); #1;
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if ({31'h0, misalign_err} !== expv) begin errors++; $display("FAIL err_clr: got %b want 0", misalign_err); end
        access(32'h21, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0); err_clr = 1'b1;
        @(negedge clk); idle(); #1;
        exp_q.push_back(32'h1);
        checks++; expv = exp_q.pop_front();
        if ({31'h0, misalign_err} !== expv) begin errors++; $display("FAIL set_beats_clr: got %b want 1", misalign_err); end
        err_clr = 1'b1;
        @(negedge clk); idle();
    endtask

    task automatic test_oob();
        @(negedge clk); access(32'h400, 32'h55555555, 1'b1, 1'b0, 2'b10, 1'b0);
        exp_q.push_back(32'h0);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL oob_rd: got %h want %h", rd, expv); end
        @(negedge clk); idle(); dbg_addr = 8'd0; #1;
        exp_q.push_back(32'h1);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL oob_set: got %b%b want 01", misalign_err, oob_err); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if (dbg_data !== expv) begin errors++; $display("FAIL oob_nowrite: got %h want %h", dbg_data, expv); end
        err_clr = 1'b1;
        @(negedge clk); access(32'h10, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0);
        exp_q.push_back(32'h0);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL size11_rd: got %h want %h", rd, expv); end
        @(negedge clk); idle(); #1;
        exp_q.push_back(32'h2);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL size11_flag: got %b%b want 10", misalign_err, oob_err); end
        err_clr = 1'b1;
        @(negedge clk); access(32'h401, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0);
        @(negedge clk); idle(); #1;
        exp_q.push_back(32'h3);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL both_flags: got %b%b want 11", misalign_err, oob_err); end
        err_clr = 1'b1;
        @(negedge clk); idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); access(32'h10, 32'h0BADCAFE, 1'b1, 1'b1, 2'b10, 1'b0);
        exp_q.push_back(32'h11AA3344);
        exp_q.push_back(32'h0BADCAFE);
        #1; checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL same_cycle_old: got %h want %h", rd, expv); end
        @(negedge clk); we = 1'b0; #1;
        checks++; expv = exp_q.pop_front();
        if (rd !== expv) begin errors++; $display("FAIL after_edge_new: got %h want %h", rd, expv); end
        exp_q.push_back(32'h0);
        checks++; expv = exp_q.pop_front();
        if ({30'h0, misalign_err, oob_err} !== expv) begin errors++; $display("FAIL clean_flags: got %b%b want 00", misalign_err, oob_err); end
        idle();
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half();
        test_misalign();
        test_oob();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
